// File: rtl/regfile_pkg.sv
// Shared register-file defaults and the register index type used by decode and writeback.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_mp_sb.sv
// Pending-write scoreboard: one bit per register, set by claim, cleared by writeback.
// Lookups are combinational and reflect this cycle's claim/write updates.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NR       = 2,
  parameter int NW       = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NW-1:0]      we,
  input  logic [NW*ADDR_W-1:0] waddr,
  input  logic               claim,
  input  logic [ADDR_W-1:0]  claim_addr,
  input  logic [NR*ADDR_W-1:0] raddr,
  output logic [NR-1:0]      busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_pend_nxt;

  // Claim is applied after the writes: the newly issued producer is younger.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int k = 0; k < NW; k++) begin
      if (we[k]) w_pend_nxt[waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (claim) w_pend_nxt[claim_addr] = 1'b1;
    if (ZERO_REG) w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pend <= '0;
    else     r_pend <= w_pend_nxt;
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NR; i++) begin
      busy[i] = w_pend_nxt[raddr[i*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write bypass and per-port pending flags.
// Read data and busy are registered; highest-index write port wins on collisions.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NR       = 2,
  parameter int NW       = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NW-1:0]        we,
  input  logic [NW*ADDR_W-1:0] waddr,
  input  logic [NW*DATA_W-1:0] wdata,
  input  logic                 claim,
  input  logic [ADDR_W-1:0]    claim_addr,
  input  logic [NR*ADDR_W-1:0] raddr,
  output logic [NR*DATA_W-1:0] rdata,
  output logic [NR-1:0]        rbusy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] r_mem;
  logic [NR-1:0][DATA_W-1:0]    w_rd;
  logic [NR-1:0]                w_busy;
  logic [NR*DATA_W-1:0]         r_rdata;
  logic [NR-1:0]                r_rbusy;

  regfile_mp_sb #(
    .ADDR_W   (ADDR_W),
    .NR       (NR),
    .NW       (NW),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .waddr      (waddr),
    .claim      (claim),
    .claim_addr (claim_addr),
    .raddr      (raddr),
    .busy       (w_busy)
  );

  // Ascending port order with non-blocking updates: the last enabled port wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '0;
    end else begin
      for (int k = 0; k < NW; k++) begin
        if (we[k] && !(ZERO_REG && waddr[k*ADDR_W +: ADDR_W] == '0)) begin
          r_mem[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NR; i++) begin
      w_rd[i] = r_mem[raddr[i*ADDR_W +: ADDR_W]];
      for (int k = 0; k < NW; k++) begin
        if (we[k] && waddr[k*ADDR_W +: ADDR_W] == raddr[i*ADDR_W +: ADDR_W]) begin
          w_rd[i] = wdata[k*DATA_W +: DATA_W];
        end
      end
      if (ZERO_REG && raddr[i*ADDR_W +: ADDR_W] == '0) w_rd[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
      r_rbusy <= '0;
    end else begin
      r_rdata <= w_rd;
      r_rbusy <= w_busy;
    end
  end

  assign rdata = r_rdata;
  assign rbusy = r_rbusy;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one instance with the zero register, one without.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       we = '0;
  logic [2*AW-1:0]  waddr = '0;
  logic [2*DW-1:0]  wdata = '0;
  logic             claim = 1'b0;
  logic [AW-1:0]    claim_addr = '0;
  logic [2*AW-1:0]  raddr = '0;
  logic [2*DW-1:0]  rdata_z, rdata_n;
  logic [1:0]       rbusy_z, rbusy_n;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NR(2), .NW(2), .ZERO_REG(1'b1)) u_z (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .claim(claim), .claim_addr(claim_addr), .raddr(raddr),
    .rdata(rdata_z), .rbusy(rbusy_z)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NR(2), .NW(2), .ZERO_REG(1'b0)) u_n (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .claim(claim), .claim_addr(claim_addr), .raddr(raddr),
    .rdata(rdata_n), .rbusy(rbusy_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0;
    claim = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 2'b01;
    waddr[AW-1:0] = a;
    wdata[DW-1:0] = d;
  endtask

  initial begin
    #1 rst = 1'b1;
    step();
    step();
    chk("rst_rdata", rdata_z[31:0], 32'h0);
    chk("rst_rbusy", {30'h0, rbusy_z}, 32'h0);
    rst = 1'b0;

    for (int a = 0; a < 32; a++) begin
      rd(AW'(a), AW'(a));
      step();
      chk("init_rd0", rdata_z[31:0], 32'h0);
      chk("init_rd1", rdata_z[63:32], 32'h0);
      chk("init_busy", {30'h0, rbusy_z}, 32'h0);
    end

    // r5=7, then asynchronous reset mid-run wipes it
    wr0(5'd5, 32'd7);
    rd(5'd5, 5'd5);
    step();
    idle();
    chk("r5_before_rst", rdata_z[31:0], 32'd7);
    step();
    chk("r5_hold", rdata_z[63:32], 32'd7);
    rst = 1'b1;
    #2;
    chk("async_rst_out", rdata_z[31:0], 32'h0);
    rst = 1'b0;
    step();
    chk("r5_after_rst", rdata_z[31:0], 32'h0);
    chk("r5_after_rst_busy", {30'h0, rbusy_z}, 32'h0);

    // read before write sees old value, same-cycle write is bypassed
    rd(5'd1, 5'd3);
    step();
    chk("r3_pre_write", rdata_z[63:32], 32'h0);
    wr0(5'd3, 32'hDEADBEEF);
    step();
    idle();
    chk("r3_bypass", rdata_z[63:32], 32'hDEADBEEF);
    step();
    chk("r3_array", rdata_z[63:32], 32'hDEADBEEF);

    // both write ports hit r9: port 1 wins
    we = 2'b11;
    waddr = {5'd9, 5'd9};
    wdata = {32'h22, 32'h11};
    rd(5'd9, 5'd9);
    step();
    idle();
    chk("r9_collide_byp", rdata_z[31:0], 32'h22);
    chk("r9_collide_p1", rdata_z[63:32], 32'h22);
    step();
    chk("r9_collide_arr", rdata_z[31:0], 32'h22);

    // claim then writeback of r4
    claim = 1'b1;
    claim_addr = 5'd4;
    rd(5'd4, 5'd4);
    step();
    idle();
    chk("r4_claim_busy", {30'h0, rbusy_z}, 32'h3);
    step();
    chk("r4_still_busy", {30'h0, rbusy_z}, 32'h3);
    wr0(5'd4, 32'd5);
    step();
    idle();
    chk("r4_wb_data", rdata_z[31:0], 32'd5);
    chk("r4_wb_busy", {30'h0, rbusy_z}, 32'h0);

    // claim and write r6 together: claim wins
    claim = 1'b1;
    claim_addr = 5'd6;
    wr0(5'd6, 32'd1);
    rd(5'd6, 5'd6);
    step();
    idle();
    chk("r6_data", rdata_z[31:0], 32'd1);
    chk("r6_busy", {30'h0, rbusy_z}, 32'h3);
    wr0(5'd6, 32'd2);
    step();
    idle();
    chk("r6_cleared_busy", {30'h0, rbusy_z}, 32'h0);
    chk("r6_new_data", rdata_z[31:0], 32'd2);

    // register 0 with and without the hardwired zero
    wr0(5'd0, 32'hFF);
    claim = 1'b1;
    claim_addr = 5'd0;
    rd(5'd0, 5'd0);
    step();
    idle();
    chk("z_r0_byp", rdata_z[31:0], 32'h0);
    chk("z_r0_busy", {30'h0, rbusy_z}, 32'h0);
    chk("n_r0_byp", rdata_n[63:32], 32'hFF);
    chk("n_r0_busy", {30'h0, rbusy_n}, 32'h3);
    step();
    chk("z_r0_arr", rdata_z[63:32], 32'h0);
    chk("n_r0_arr", rdata_n[31:0], 32'hFF);
    chk("n_r0_busy2", {30'h0, rbusy_n}, 32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
